// File: rtl/gfx_calc_coord_pkg.sv
// Shared definitions for the graphics coordinate calculators.
// Holds the colour-depth codes, the FSM state type and the per-depth strip packing functions.
package gfx_calc_coord_pkg;

   localparam int ADDR_W  = 32;
   localparam int COORD_W = 16;
   localparam int CD_W    = 4;

   typedef enum logic [3:0] {
      BPP6  = 4'd0,
      BPP8  = 4'd1,
      BPP12 = 4'd2,
      BPP16 = 4'd3,
      BPP24 = 4'd4,
      BPP32 = 4'd5,
      BPP40 = 4'd6
   } color_depth_e;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      DIV,
      FIN,
      DONE
   } state_e;

   // Unknown codes report zero bits so every derived quantity collapses to zero.
   function automatic int depth_bits(input logic [3:0] cd);
      int bits;
      case (cd)
         BPP6:    bits = 6;
         BPP8:    bits = 8;
         BPP12:   bits = 12;
         BPP16:   bits = 16;
         BPP24:   bits = 24;
         BPP32:   bits = 32;
         BPP40:   bits = 40;
         default: bits = 0;
      endcase
      return bits;
   endfunction

   function automatic logic [15:0] depth_coeff(input logic [3:0] cd, input int sw);
      return 16'((65536 * depth_bits(cd)) / sw);
   endfunction

   function automatic logic [5:0] depth_bpp(input logic [3:0] cd);
      int bits;
      bits = depth_bits(cd);
      return (bits == 0) ? 6'd0 : 6'(bits - 1);
   endfunction

   function automatic logic [15:0] depth_coeff2(input logic [3:0] cd, input int sw);
      int bits;
      bits = depth_bits(cd);
      return (bits == 0) ? 16'd0 : 16'(sw - (sw % bits));
   endfunction

   // Whole pixels that fit in one strip; the leftover bits of a strip are never used.
   function automatic logic [7:0] depth_pps(input logic [3:0] cd, input int sw);
      int bits;
      bits = depth_bits(cd);
      return (bits == 0) ? 8'd0 : 8'((sw - (sw % bits)) / bits);
   endfunction

endpackage

// File: rtl/gfx_calc_coord_if.sv
// Request/done bus between a client and the coordinate calculator.
interface gfx_calc_coord_if
   import gfx_calc_coord_pkg::*;
#(
   parameter int BN = 6
);
   logic               req_i;
   logic [ADDR_W-1:0]  base_address_i;
   logic [ADDR_W-1:0]  address_i;
   logic [BN:0]        bit_i;
   logic [CD_W-1:0]    color_depth_i;
   logic [COORD_W-1:0] bmp_width_i;
   logic               busy_o;
   logic               done_o;
   logic               err_o;
   logic [COORD_W-1:0] x_coord_o;
   logic [COORD_W-1:0] y_coord_o;

   modport master (
      output req_i, base_address_i, address_i, bit_i, color_depth_i, bmp_width_i,
      input  busy_o, done_o, err_o, x_coord_o, y_coord_o
   );

   modport slave (
      input  req_i, base_address_i, address_i, bit_i, color_depth_i, bmp_width_i,
      output busy_o, done_o, err_o, x_coord_o, y_coord_o
   );
endinterface

// File: rtl/gfx_calc_coord_restoring_div.sv
// Iterative restoring divider producing one quotient bit per clock, MSB first.
// start_i performs the first step; done_o rises once the last bit is in and stays high until the next start.
module gfx_restoring_div
   import gfx_calc_coord_pkg::*;
#(
   parameter int DDW = 28,
   parameter int DVW = 16
) (
   input  logic           clk,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [DDW-1:0] dividend_i,
   input  logic [DVW-1:0] divisor_i,
   output logic [DDW-1:0] quot_o,
   output logic [DVW-1:0] rem_o,
   output logic           done_o
);

   localparam int CW = $clog2(DDW + 1);

   logic [DDW-1:0] quo_q, quo_d, quo_src;
   logic [DVW-1:0] rem_q, rem_d, rem_src;
   logic [DVW-1:0] dsr_q, dsr_d, dsr_src;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;
   logic [DVW:0]   shifted;
   logic [DVW:0]   diff;

   // The partial remainder stays below the divisor, so one extra bit is enough for the trial subtract.
   always_comb begin
      quo_src = start_i ? dividend_i : quo_q;
      rem_src = start_i ? '0         : rem_q;
      dsr_src = start_i ? divisor_i  : dsr_q;
      shifted = {rem_src, quo_src[DDW-1]};
      diff    = shifted - {1'b0, dsr_src};

      quo_d  = quo_q;
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      done_d = done_q;

      if (start_i || (cnt_q != '0)) begin
         quo_d  = {quo_src[DDW-2:0], ~diff[DVW]};
         rem_d  = diff[DVW] ? shifted[DVW-1:0] : diff[DVW-1:0];
         dsr_d  = dsr_src;
         cnt_d  = start_i ? CW'(DDW - 1) : cnt_q - CW'(1);
         done_d = start_i ? (DDW == 1) : (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign quot_o = quo_q;
   assign rem_o  = rem_q;
   assign done_o = done_q;

endmodule

// File: rtl/gfx_calc_coord.sv
// Converts a strip byte address plus bit position back into pixel (x, y) coordinates.
// Strip index = y * strips_per_line + strip_in_line; both parts come out of one iterative divide.
module gfx_calc_coord
   import gfx_calc_coord_pkg::*;
#(
   parameter int SW = 128,
   parameter int BN = 6
) (
   input  logic              clk,
   input  logic              rst_i,
   gfx_calc_coord_if.slave   bus
);

   localparam int SB     = $clog2(SW / 8);
   localparam int SIDX_W = ADDR_W - SB;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BN:0]        bit_q, bit_d;
   logic [CD_W-1:0]    depth_q, depth_d;
   logic [COORD_W-1:0] width_q, width_d;
   logic               err_q, err_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   logic [15:0]        coeff;
   logic [15:0]        coeff2;
   logic [7:0]         pps;
   logic [5:0]         pw;
   logic [15:0]        nstr;
   logic [SIDX_W-1:0]  sidx;
   logic               setup_err;
   logic               div_start;

   logic [SIDX_W-1:0]  quot;
   logic [15:0]        rem;
   logic               quot_done;
   logic [BN:0]        pix;
   logic               pix_done;

   // Per-depth strip geometry, all derived from the latched request.
   always_comb begin
      coeff     = depth_coeff(depth_q, SW);
      coeff2    = depth_coeff2(depth_q, SW);
      pps       = depth_pps(depth_q, SW);
      pw        = depth_bpp(depth_q) + 6'd1;
      nstr      = 16'(({16'b0, width_q} * {16'b0, coeff}) >> 16);
      sidx      = SIDX_W'((addr_q - base_q) >> SB);
      setup_err = (addr_q < base_q) || (nstr == 16'd0) || (16'(bit_q) >= coeff2);
   end

   gfx_restoring_div #(
      .DDW (SIDX_W),
      .DVW (16)
   ) u_strip_div (
      .clk        (clk),
      .rst_i      (rst_i),
      .start_i    (div_start),
      .dividend_i (sidx),
      .divisor_i  (nstr),
      .quot_o     (quot),
      .rem_o      (rem),
      .done_o     (quot_done)
   );

   gfx_restoring_div #(
      .DDW (BN + 1),
      .DVW (6)
   ) u_pix_div (
      .clk        (clk),
      .rst_i      (rst_i),
      .start_i    (div_start),
      .dividend_i (bit_q),
      .divisor_i  (pw),
      .quot_o     (pix),
      .rem_o      (),
      .done_o     (pix_done)
   );

   // Next-state and datapath updates; requests outside IDLE are simply dropped.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      addr_d    = addr_q;
      bit_d     = bit_q;
      depth_d   = depth_q;
      width_d   = width_q;
      err_d     = err_q;
      x_d       = x_q;
      y_d       = y_q;
      div_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               base_d  = bus.base_address_i;
               addr_d  = bus.address_i;
               bit_d   = bus.bit_i;
               depth_d = bus.color_depth_i;
               width_d = bus.bmp_width_i;
               err_d   = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (setup_err) begin
               err_d   = 1'b1;
               x_d     = '0;
               y_d     = '0;
               state_d = DONE;
            end else begin
               div_start = 1'b1;
               state_d   = DIV;
            end
         end
         DIV: begin
            if (quot_done && pix_done) begin
               state_d = FIN;
            end
         end
         FIN: begin
            if (|quot[SIDX_W-1:16]) begin
               err_d = 1'b1;
               x_d   = '0;
               y_d   = '0;
            end else begin
               y_d = quot[15:0];
               x_d = 16'(({8'b0, rem} * {16'b0, pps}) + {{(24-BN-1){1'b0}}, pix});
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         bit_q   <= '0;
         depth_q <= '0;
         width_q <= '0;
         err_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         bit_q   <= bit_d;
         depth_q <= depth_d;
         width_q <= width_d;
         err_q   <= err_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign bus.busy_o    = (state_q != IDLE);
   assign bus.done_o    = (state_q == DONE);
   assign bus.err_o     = err_q;
   assign bus.x_coord_o = x_q;
   assign bus.y_coord_o = y_q;

endmodule

// File: tb/tb_gfx_calc_coord.sv
// Directed vectors, handshake corner cases and a forward-model round trip for gfx_calc_coord.
module tb_gfx_calc_coord;
   import gfx_calc_coord_pkg::*;

   localparam int SW = 128;
   localparam int BN = 6;

   logic clk   = 1'b0;
   logic rst_i = 1'b0;

   gfx_calc_coord_if #(.BN(BN)) bus ();

   gfx_calc_coord #(.SW(SW), .BN(BN)) dut (
      .clk   (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cd;
      logic [15:0] width;
      logic [31:0] base;
      logic [31:0] addr;
      logic [BN:0] bit_idx;
      logic        exp_err;
      logic [15:0] exp_x;
      logic [15:0] exp_y;
      int          exp_lat;
   } vec_t;

   int checks = 0;
   int passed = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic driveFields(input vec_t v);
      bus.color_depth_i  = v.cd;
      bus.bmp_width_i    = v.width;
      bus.base_address_i = v.base;
      bus.address_i      = v.addr;
      bus.bit_i          = v.bit_idx;
   endtask

   // Issues one request from IDLE; lat is the cycle done_o is seen (acceptance edge ends cycle 0), 0 on timeout.
   task automatic applyStimulus(input vec_t v, output int lat, output logic busy_at_done,
                                output logic e, output logic [15:0] x, output logic [15:0] y);
      @(posedge clk); #1;
      driveFields(v);
      bus.req_i = 1'b1;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      lat = 0;
      for (int c = 1; c <= 60; c++) begin
         if (bus.done_o) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      busy_at_done = bus.busy_o;
      e = bus.err_o;
      x = bus.x_coord_o;
      y = bus.y_coord_o;
   endtask

   vec_t vecs[13];
   logic [3:0] cd_tab[7];
   int         bits_tab[7];

   initial begin
      int          lat;
      logic        bsy, e;
      logic [15:0] x, y;
      int          done_cnt, first_done, second_done;
      logic        busy_gap;

      vecs[0]  = '{BPP16, 16'd640,  32'h0001_0000, 32'h0001_0FC0, 7'd64,  1'b0, 16'd100,  16'd3,     31};
      vecs[1]  = '{BPP8,  16'd1024, 32'h0000_0000, 32'h000B_FFF0, 7'd120, 1'b0, 16'd1023, 16'd767,   31};
      vecs[2]  = '{BPP24, 16'd800,  32'h0000_0100, 32'h0000_00FF, 7'd0,   1'b1, 16'd0,    16'd0,     2};
      vecs[3]  = '{BPP24, 16'd800,  32'h0000_0100, 32'h0000_1000, 7'd124, 1'b1, 16'd0,    16'd0,     2};
      vecs[4]  = '{BPP24, 16'd800,  32'h0000_0100, 32'h0000_1000, 7'd119, 1'b0, 16'd454,  16'd1,     31};
      vecs[5]  = '{BPP16, 16'd0,    32'h0000_0000, 32'h0000_0040, 7'd0,   1'b1, 16'd0,    16'd0,     2};
      vecs[6]  = '{BPP40, 16'd1,    32'h0000_0000, 32'h0020_0000, 7'd0,   1'b1, 16'd0,    16'd0,     2};
      vecs[7]  = '{BPP40, 16'd4,    32'h0000_0000, 32'h0020_0000, 7'd0,   1'b1, 16'd0,    16'd0,     31};
      vecs[8]  = '{BPP32, 16'd320,  32'h0000_2000, 32'h0000_200F, 7'd96,  1'b0, 16'd3,    16'd0,     31};
      vecs[9]  = '{BPP6,  16'd1000, 32'h4000_0000, 32'h4000_1234, 7'd125, 1'b0, 16'd335,  16'd6,     31};
      vecs[10] = '{BPP12, 16'd2000, 32'h0000_0000, 32'h0BAF_F4A7, 7'd119, 1'b0, 16'd59,   16'd65535, 31};
      vecs[11] = '{BPP12, 16'd2000, 32'h0000_0000, 32'h0BB0_0000, 7'd0,   1'b1, 16'd0,    16'd0,     31};
      vecs[12] = '{BPP8,  16'd100,  32'hFFFF_FFF0, 32'h0000_0010, 7'd0,   1'b1, 16'd0,    16'd0,     2};

      cd_tab   = '{BPP6, BPP8, BPP12, BPP16, BPP24, BPP32, BPP40};
      bits_tab = '{6, 8, 12, 16, 24, 32, 40};

      bus.req_i          = 1'b0;
      bus.color_depth_i  = '0;
      bus.bmp_width_i    = '0;
      bus.base_address_i = '0;
      bus.address_i      = '0;
      bus.bit_i          = '0;

      #1 rst_i = 1'b1;
      #2;
      checkOutput("reset.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("reset.done", 32'(bus.done_o), 32'd0);
      checkOutput("reset.err",  32'(bus.err_o),  32'd0);
      checkOutput("reset.x",    32'(bus.x_coord_o), 32'd0);
      checkOutput("reset.y",    32'(bus.y_coord_o), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_i = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i], lat, bsy, e, x, y);
         checkOutput($sformatf("v%0d.lat", i),  32'(lat), 32'(vecs[i].exp_lat));
         checkOutput($sformatf("v%0d.busy", i), 32'(bsy), 32'd1);
         checkOutput($sformatf("v%0d.err", i),  32'(e),   32'(vecs[i].exp_err));
         checkOutput($sformatf("v%0d.x", i),    32'(x),   32'(vecs[i].exp_x));
         checkOutput($sformatf("v%0d.y", i),    32'(y),   32'(vecs[i].exp_y));
      end

      $display("[TB] req held through an operation and into DONE");
      @(posedge clk); #1;
      driveFields(vecs[0]);
      bus.req_i = 1'b1;
      @(posedge clk);
      done_cnt = 0; first_done = 0; second_done = 0; busy_gap = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         #1;
         if (bus.done_o) begin
            done_cnt++;
            if (first_done == 0) first_done = c;
            else if (second_done == 0) second_done = c;
            if (done_cnt == 2) bus.req_i = 1'b0;
         end
         if (c == 32) busy_gap = bus.busy_o;
         @(posedge clk);
      end
      #1;
      checkOutput("held.done_count", 32'(done_cnt), 32'd2);
      checkOutput("held.first_done", 32'(first_done), 32'd31);
      checkOutput("held.second_done", 32'(second_done), 32'd63);
      checkOutput("held.idle_gap_busy", 32'(busy_gap), 32'd0);
      checkOutput("held.x", 32'(bus.x_coord_o), 32'd100);
      checkOutput("held.y", 32'(bus.y_coord_o), 32'd3);

      $display("[TB] reset during the divide");
      @(posedge clk); #1;
      driveFields(vecs[1]);
      bus.req_i = 1'b1;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_i = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("abort.done", 32'(bus.done_o), 32'd0);
      checkOutput("abort.err",  32'(bus.err_o),  32'd0);
      checkOutput("abort.x",    32'(bus.x_coord_o), 32'd0);
      checkOutput("abort.y",    32'(bus.y_coord_o), 32'd0);
      @(negedge clk) rst_i = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.done_o) done_cnt++;
      end
      checkOutput("abort.no_done", 32'(done_cnt), 32'd0);

      $display("[TB] forward-model round trip");
      for (int i = 0; i < 200; i++) begin
         vec_t v;
         int   k, bits, coeff, nstr, pps, limit, xi, yi, strip;
         k     = $urandom_range(0, 6);
         bits  = bits_tab[k];
         v.cd  = cd_tab[k];
         v.width = 16'($urandom_range(64, 4000));
         coeff = (65536 * bits) / SW;
         nstr  = (int'(v.width) * coeff) >>> 16;
         pps   = (SW - (SW % bits)) / bits;
         limit = (nstr * pps < int'(v.width)) ? nstr * pps : int'(v.width);
         xi    = $urandom_range(0, limit - 1);
         yi    = $urandom_range(0, 3000);
         strip = yi * nstr + xi / pps;
         v.base    = 32'($urandom_range(0, 32'h7FFF_FFFF));
         v.addr    = v.base + (32'(strip) << 4) + 32'($urandom_range(0, 15));
         v.bit_idx = (BN+1)'((xi % pps) * bits);
         v.exp_err = 1'b0;
         v.exp_x   = 16'(xi);
         v.exp_y   = 16'(yi);
         v.exp_lat = 31;
         applyStimulus(v, lat, bsy, e, x, y);
         checkOutput($sformatf("rt%0d.lat", i), 32'(lat), 32'(v.exp_lat));
         checkOutput($sformatf("rt%0d.err", i), 32'(e),   32'(v.exp_err));
         checkOutput($sformatf("rt%0d.x", i),   32'(x),   32'(v.exp_x));
         checkOutput($sformatf("rt%0d.y", i),   32'(y),   32'(v.exp_y));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
